scb_spi_responder: RTL
======================

Name: scb_spi_responder

Overview:
- Slave/responder end of the slow-control SPI link (MCSn/MSK/MDO/MDI/nIRQ), driven by the readout-board SPI master.
- Instantiated as a board-level loopback and emulation target for the slow-control board.
- Oversamples the master's SPI lines on its own clock, deserialises 8–136 bit frames MSB first, and returns read data on MDI.
- After each good frame, drives the nIRQ busy flag low so the master waits.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on MCSn, MSK and MDO (min 2).
- BUSY_CYCLES, 16: nIRQ low time in clk cycles after a valid frame (min 1).
- MAX_BITS, 136: maximum bits accepted per frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- SCB_MCSn  in  1  chip select from master, active low
- SCB_MSK  in  1  SPI clock from master
- SCB_MDO  in  1  master data out (slave data in)
- SCB_MDI  out  1  slave data out to master
- SCB_nIRQ  out  1  busy flag, low = busy
- tx_data  in  128  response payload, returned on frame bytes 1..16
- ext_busy  in  1  holds SCB_nIRQ low while high
- rx_data  out  136  received bits; last received bit at [0]
- rx_cmd  out  8  first byte of the current frame
- rx_bits  out  8  bits received in the last frame
- frame_valid  out  1  one-cycle pulse: good frame ended
- frame_err  out  1  one-cycle pulse: bad frame ended
- in_frame  out  1  high while a frame is active

Behaviour:
- Reset (synchronous, active-high rst):
  - Outputs after reset: SCB_MDI=0, SCB_nIRQ=1, rx_data=0, rx_cmd=0, rx_bits=0, frame_valid=0, frame_err=0, in_frame=0.
  - Synchroniser flops are cleared to idle: MCSn=1, MSK=0, MDO=0.
- Input handling:
  - All three inputs pass through SYNC_STAGES flops.
  - Edge detection compares the last sync stage with one extra register.
  - Edge latency from pin: SYNC_STAGES+1 clk.
- States:
  - IDLE:
    - in_frame=0, SCB_MDI=0.
    - On a synced MCSn falling edge: snapshot tx_data into tx_snap, clear the bit counter k, clear the overflow flag, set in_frame, go to RX.
  - RX, on synced MSK rising edge:
    - If k<MAX_BITS: rx_shift<={rx_shift[134:0],MDO_sync}; k<=k+1.
    - If k=8 after the shift: rx_cmd<=rx_shift[6:0]&MDO, the 8 bits just received.
    - If k>=MAX_BITS: set overflow; data and k are unchanged.
  - RX, on synced MSK falling edge: SCB_MDI<=bit(k), where k is the already-incremented count.
  - RX, on synced MCSn rising edge:
    - Copy rx_shift to rx_data and k to rx_bits. Go to IDLE, SCB_MDI<=0.
    - If k>0, k%8==0 and no overflow: pulse frame_valid, load the busy counter with BUSY_CYCLES.
    - Else if k>0: pulse frame_err; the busy counter is not loaded.
    - If k=0: no pulse.
- MDI bit function:
  - bit(k)=0 for k<8, because the master discards the command-byte readback.
  - bit(k)=tx_snap[127-(k-8)] for 8<=k<136.
  - bit(k)=0 for k>=136.
  - On entry to RX, SCB_MDI=bit(0)=0, valid before the first MSK rise.
- Timing margin: the master keeps MSK high for 11 master clk and low for 22, so the post-falling-edge update reaches the pin well before the next rise. This holds when clk ≥ the master clock.
- Simultaneous events: if an MCSn rise and an MSK edge are detected in the same cycle, the MCSn rise wins and the MSK edge is ignored.
- MSK edges seen in IDLE are ignored.
- Busy:
  - The busy counter decrements to 0.
  - SCB_nIRQ=0 while counter≠0 or ext_busy=1, else 1. It is registered, one clk after the cause.
  - A new frame may start while busy; a new valid frame reloads the counter.
- Reset mid-frame: everything returns to reset values. If the synced MCSn is already low when rst drops, no frame starts; a new frame needs an MCSn rise then fall.
- rx_data, rx_cmd and rx_bits hold their values until the next frame end (rx_cmd updates at the 8th bit).

Test Plan:
- 16-bit frame, MDO=0xA55A, master phase 11 clk → rx_bits=16, rx_data[15:0]=0xA55A, rx_cmd=0xA5, frame_valid one pulse, SCB_nIRQ low exactly 16 clk, then high.
- 136-bit frame, tx_data=0x00112233_44556677_8899AABB_CCDDEEFF → master readback bytes 1..16 = 0x00..0xFF in order, byte 0 readback=0x00, frame_valid.
- 12-bit frame → frame_err pulse, rx_bits=12, SCB_nIRQ stays 1; 137 MSK pulses → rx_bits=136, frame_err.
- ext_busy high for 50 clk spanning a valid frame end → SCB_nIRQ low for max(BUSY_CYCLES, remaining ext_busy) and releases 1 clk after both clear.
- rst asserted after 5 bits with MCSn still low → outputs at reset values. Subsequent MSK pulses while MCSn low are ignored. Next MCSn high→low frame of 8 bits 0x3C → rx_cmd=0x3C, frame_valid.
- MCSn rise coincident (same synced cycle) with an 8th MSK rise → that edge ignored, rx_bits=7, frame_err.

Source files
------------

// File: rtl/scb_spi_responder.sv
// Slow-control SPI responder: oversamples MCSn/MSK/MDO, deserialises MSB-first frames,
// returns tx_data on MDI and drives the nIRQ busy flag after each good frame.
module scb_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUSY_CYCLES = 16,
  parameter int unsigned MAX_BITS    = 136
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         SCB_MCSn,
  input  logic         SCB_MSK,
  input  logic         SCB_MDO,
  output logic         SCB_MDI,
  output logic         SCB_nIRQ,
  input  logic [127:0] tx_data,
  input  logic         ext_busy,
  output logic [135:0] rx_data,
  output logic [7:0]   rx_cmd,
  output logic [7:0]   rx_bits,
  output logic         frame_valid,
  output logic         frame_err,
  output logic         in_frame
);

  localparam logic [7:0]  MaxBits = 8'(MAX_BITS);
  localparam int unsigned WarmMax = SYNC_STAGES + 1;
  localparam int unsigned WarmW   = $clog2(WarmMax + 1);
  localparam int unsigned BusyW   = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StRx} state_e;

  logic [SYNC_STAGES-1:0] mcsn_sync, msk_sync, mdo_sync;
  logic                   mcsn_d, msk_d;
  logic [WarmW-1:0]       warm_q;
  logic                   armed;
  logic                   mcsn_s, msk_s, mdo_s;
  logic                   mcsn_fall, mcsn_rise, msk_rise, msk_fall;

  state_e                 state;
  logic [127:0]           tx_snap;
  logic [135:0]           rx_shift;
  logic [7:0]             k_q;
  logic                   ovf_q;
  logic [BusyW-1:0]       busy_cnt;
  logic [6:0]             tx_idx;
  logic                   mdi_bit;

  assign mcsn_s = mcsn_sync[SYNC_STAGES-1];
  assign msk_s  = msk_sync[SYNC_STAGES-1];
  assign mdo_s  = mdo_sync[SYNC_STAGES-1];

  // Edges are masked until the reset values have flushed out of the synchronisers, so a
  // chip select already low when reset drops never looks like a falling edge.
  assign armed     = (warm_q == WarmW'(WarmMax));
  assign mcsn_fall = armed & mcsn_d & ~mcsn_s;
  assign mcsn_rise = armed & ~mcsn_d & mcsn_s;
  assign msk_rise  = armed & ~msk_d & msk_s;
  assign msk_fall  = armed & msk_d & ~msk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcsn_sync <= '1;
      msk_sync  <= '0;
      mdo_sync  <= '0;
      mcsn_d    <= 1'b1;
      msk_d     <= 1'b0;
      warm_q    <= '0;
    end else begin
      mcsn_sync <= {mcsn_sync[SYNC_STAGES-2:0], SCB_MCSn};
      msk_sync  <= {msk_sync[SYNC_STAGES-2:0], SCB_MSK};
      mdo_sync  <= {mdo_sync[SYNC_STAGES-2:0], SCB_MDO};
      mcsn_d    <= mcsn_s;
      msk_d     <= msk_s;
      if (!armed) warm_q <= warm_q + WarmW'(1);
    end
  end

  // Payload bit for the already-incremented count; byte 0 readback is always zero.
  assign tx_idx = 7'(8'd135 - k_q);
  always_comb begin
    mdi_bit = 1'b0;
    if (k_q >= 8'd8 && k_q < 8'd136) mdi_bit = tx_snap[tx_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      tx_snap     <= '0;
      rx_shift    <= '0;
      k_q         <= '0;
      ovf_q       <= 1'b0;
      busy_cnt    <= '0;
      SCB_MDI     <= 1'b0;
      SCB_nIRQ    <= 1'b1;
      rx_data     <= '0;
      rx_cmd      <= '0;
      rx_bits     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      in_frame    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      SCB_nIRQ    <= ~((busy_cnt != '0) | ext_busy);
      if (busy_cnt != '0) busy_cnt <= busy_cnt - BusyW'(1);

      unique case (state)
        StIdle: begin
          if (mcsn_fall) begin
            tx_snap  <= tx_data;
            rx_shift <= '0;
            k_q      <= '0;
            ovf_q    <= 1'b0;
            in_frame <= 1'b1;
            SCB_MDI  <= 1'b0;
            state    <= StRx;
          end
        end
        StRx: begin
          // Chip-select release takes priority over any MSK edge in the same cycle.
          if (mcsn_rise) begin
            rx_data  <= rx_shift;
            rx_bits  <= k_q;
            SCB_MDI  <= 1'b0;
            in_frame <= 1'b0;
            state    <= StIdle;
            if (k_q != '0 && k_q[2:0] == 3'd0 && !ovf_q) begin
              frame_valid <= 1'b1;
              busy_cnt    <= BusyW'(BUSY_CYCLES);
            end else if (k_q != '0) begin
              frame_err <= 1'b1;
            end
          end else if (msk_rise) begin
            if (k_q < MaxBits) begin
              rx_shift <= {rx_shift[134:0], mdo_s};
              k_q      <= k_q + 8'd1;
              if (k_q == 8'd7) rx_cmd <= {rx_shift[6:0], mdo_s};
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (msk_fall) begin
            SCB_MDI <= mdi_bit;
          end
        end
      endcase
    end
  end

endmodule
